ysyx_25060170_exu_ctrl: RTL

- Multi-cycle sequencer for the single-issue core. It owns the architectural PC and steps each instruction through fetch, decode/execute, optional memory access and writeback.
- Issues fetch and memory requests with valid/ready handshakes, latches the instruction for IDU/EXU, and strobes the register-file write.
- Selects the next PC: the EXU jump address when jal/jalr is active, otherwise PC+4.
- Sits between IFU, IDU/EXU, LSU and WBU; it is the only writer of the PC.

---
 rtl/ysyx_25060170_pkg.sv | 18 +
 rtl/ysyx_25060170_timeout_cnt.sv | 28 ++
 rtl/ysyx_25060170_exu_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/ysyx_25060170_pkg.sv
// Shared state encoding and constants for the ysyx_25060170 execute-control slice.
package ysyx_25060170_pkg;

   typedef enum logic [2:0] {
      FETCH_REQ  = 3'd0,
      FETCH_WAIT = 3'd1,
      EXEC       = 3'd2,
      MEM_REQ    = 3'd3,
      MEM_WAIT   = 3'd4,
      WB         = 3'd5,
      HALT       = 3'd6,
      ERR        = 3'd7
   } exu_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25060170_timeout_cnt.sv
// 8-bit wait counter with clear/enable; expire marks the LIMIT-th consecutive enabled cycle.
module ysyx_25060170_timeout_cnt
   import ysyx_25060170_pkg::*;
#(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [7:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (enable && count != LIMIT)
         count <= count + 8'd1;
   end

   // count holds the number of earlier enabled cycles, so LIMIT-1 means this is the last one
   always_comb begin
      expire = enable && (count == LIMIT - 8'd1);
   end

endmodule

// File: rtl/ysyx_25060170_exu_ctrl.sv
// Multi-cycle sequencer owning the architectural PC; optional counters via YSYX_25060170_PERF_EN.
module ysyx_25060170_exu_ctrl
   import ysyx_25060170_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_inst,
   output logic [31:0] inst,
   input  logic        exu_is_jal,
   input  logic        exu_is_jalr,
   input  logic        is_mem,
   input  logic        is_ebreak,
   input  logic [31:0] jump_addr,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_rsp_valid,
   output logic        reg_wen,
   output logic [31:0] pc,
   output logic        halt,
   output logic        err
`ifdef YSYX_25060170_PERF_EN
   ,
   output logic [63:0] perf_cycles,
   output logic [63:0] perf_instret
`endif
);

   exu_state_t state, state_next;
   logic       tmo_clear, tmo_en, tmo_expire;

   ysyx_25060170_timeout_cnt #(
      .LIMIT (8'(MEM_TIMEOUT))
   ) u_timeout_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (tmo_en),
      .expire (tmo_expire)
   );

   always_ff @(posedge clock) begin
      if (reset)
         state <= FETCH_REQ;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH_REQ:  if (ifu_req_ready) state_next = FETCH_WAIT;
         FETCH_WAIT: if (ifu_rsp_valid) state_next = EXEC;
                     else if (tmo_expire) state_next = ERR;
         EXEC:       if (is_ebreak) state_next = HALT;
                     else if (is_mem) state_next = MEM_REQ;
                     else state_next = WB;
         MEM_REQ:    if (lsu_req_ready) state_next = MEM_WAIT;
         MEM_WAIT:   if (lsu_rsp_valid) state_next = WB;
                     else if (tmo_expire) state_next = ERR;
         WB:         state_next = FETCH_REQ;
         default:    state_next = state;
      endcase
   end

   // Wait counter restarts whenever the state moves, so each wait phase gets a full window
   always_comb begin
      tmo_en    = (state == FETCH_WAIT) || (state == MEM_WAIT);
      tmo_clear = (state_next != state);
   end

   always_comb begin
      ifu_req_valid = (state == FETCH_REQ);
      ifu_req_addr  = pc;
      lsu_req_valid = (state == MEM_REQ);
      reg_wen       = (state == WB);
      halt          = (state == HALT);
      err           = (state == ERR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc   <= RESET_PC;
         inst <= '0;
      end else begin
         if (state == FETCH_WAIT && ifu_rsp_valid)
            inst <= ifu_rsp_inst;
         if (state == WB)
            pc <= (exu_is_jal || exu_is_jalr) ? jump_addr : pc + 32'd4;
      end
   end

`ifdef YSYX_25060170_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_cycles  <= '0;
         perf_instret <= '0;
      end else if (state != HALT && state != ERR) begin
         perf_cycles <= perf_cycles + 64'd1;
         if (state == WB || (state == EXEC && is_ebreak))
            perf_instret <= perf_instret + 64'd1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule
